mips_timer: RTL and testbench
=============================

Name: mips_timer

Overview:
- Memory-mapped timer/counter peripheral on the CPU data-memory bus, directly downstream of the MEM-stage outputs (memaddr, memwrite, memwritedata) and feeding memreaddata through the system read mux.
- Provides a free-running or one-shot 32-bit counter, a compare register, a sticky match flag and a level interrupt request.
- Register reads are combinational so the MEM stage gets data in the same cycle.

Parameters:
- ADDR_W, 4, width of byte-offset address; registers sit at word offsets 0x0/0x4/0x8/0xC, addr[1:0] ignored.
- RESET_CMP, 32'hFFFFFFFF, reset value of COMPARE.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- cs  input  1  chip select from the system address decoder, valid with addr/we/wdata.
- we  input  1  write strobe (CPU memwrite qualified by cs).
- addr  input  ADDR_W  byte offset within the timer window.
- wdata  input  32  write data (CPU memwritedata).
- rdata  output  32  read data, combinational.
- irq  output  1  level interrupt, high while STATUS.match & CTRL.irqen.

Behaviour:
- Registers:
  - CTRL @0x0: [0] en, [1] autoreload, [2] irqen, [15:8] presc, others read 0.
  - COUNT @0x4.
  - COMPARE @0x8.
  - STATUS @0xC: [0] match, write-1-to-clear.
- Reset (async): CTRL=0, COUNT=0, COMPARE=RESET_CMP, STATUS=0, internal prescaler=0, irq=0. rdata=0 unless cs=1 & we=0.
- Read:
  - rdata = selected register when cs=1 & we=0, else 32'h0. No side effects; reading STATUS does not clear it.
  - Reads reflect register state before the current clock edge.
- Write: when cs=1 & we=1, the addressed register is updated at the rising edge.
  - Write to STATUS: match cleared where wdata[0]=1.
  - Write to COUNT also resets the prescaler to 0.
- Prescaler:
  - While en=1, it counts 0..presc, then wraps to 0.
  - tick = en & (prescaler==presc). presc=0 gives a tick every cycle; presc=N gives a tick every N+1 cycles.
  - en=0 holds both the prescaler and COUNT.
- On tick:
  - If COUNT==COMPARE: set match=1.
    - autoreload=1: COUNT<=0.
    - autoreload=0: COUNT holds and CTRL.en<=0 (one-shot stop).
  - Else COUNT<=COUNT+1, wrapping 32'hFFFFFFFF to 0 with no flag.
- Priority in the same cycle:
  - CPU write to COUNT beats tick update.
  - CPU write to CTRL beats the one-shot en clear.
  - match set by tick beats a write-1-to-clear in the same cycle, so match stays 1.
- irq is combinational from registered state: irq = match & irqen. Clearing irqen masks irq without clearing match.
- Reset asserted mid-count: all state returns to reset values asynchronously. The counter does not resume after reset deassertion until CTRL is written.
- Accesses with cs=0 have no effect regardless of we/addr.

Test Plan:
- Reset then read all four offsets -> rdata 0,0,FFFFFFFF,0; irq=0. Assert reset mid-count with COUNT=5 -> COUNT reads 0 immediately after the async edge.
- Write COMPARE=3, CTRL=0x5 (en, irqen, presc=0), then poll -> COUNT reads 1,2,3 on successive cycles; match and irq rise on the tick after COUNT=3; en reads 0; COUNT stays 3.
- CTRL=0x0307 (en, autoreload, irqen, presc=3), COMPARE=2 -> COUNT increments every 4 cycles 0,1,2,0; match set when 2 wraps to 0. Writing STATUS=1 clears match and irq next cycle.
- With autoreload, arrange a match tick in the same cycle as a STATUS=1 write -> match remains 1. Write COUNT=7 on a tick cycle -> COUNT reads 7, not the incremented value.
- COUNT=FFFFFFFE, COMPARE=10, presc=0, en=1 -> COUNT goes FFFFFFFF, 00000000, 00000001; match stays 0.
- cs=0 with we=1 to each offset -> no register changes and rdata=0. match=1 with irqen=0 -> irq=0; setting irqen -> irq=1 in the same cycle the write takes effect.

Source files
------------

// File: rtl/mips_timer.sv
`default_nettype none
// ============================================================================
// Module   : mips_timer
// Brief    : Memory-mapped 32-bit timer/counter on the CPU data bus, with
//            prescaler, compare match, sticky match flag and level IRQ.
// Revision : 1.0  initial release
// ============================================================================
module mips_timer #(
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    localparam logic [1:0] c_reg_ctrl    = 2'd0;
    localparam logic [1:0] c_reg_count   = 2'd1;
    localparam logic [1:0] c_reg_compare = 2'd2;
    localparam logic [1:0] c_reg_status  = 2'd3;

    logic        r_en;
    logic        r_autoreload;
    logic        r_irqen;
    logic [7:0]  r_presc;
    logic [7:0]  r_prescaler;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;

    logic        w_hi_zero;
    logic [1:0]  w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_hit_cmp;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Offsets beyond the four word registers only decode when the window is wider.
    generate
        if (ADDR_W > 4) begin : g_addr_hi
            assign w_hi_zero = ~|addr[ADDR_W-1:4];
        end else begin : g_addr_narrow
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    assign w_sel        = addr[3:2];
    assign w_wr         = cs & we & w_hi_zero;
    assign w_rd         = cs & ~we & w_hi_zero;
    assign w_wr_ctrl    = w_wr & (w_sel == c_reg_ctrl);
    assign w_wr_count   = w_wr & (w_sel == c_reg_count);
    assign w_wr_compare = w_wr & (w_sel == c_reg_compare);
    assign w_wr_status  = w_wr & (w_sel == c_reg_status);

    assign w_tick    = r_en & (r_prescaler == r_presc);
    assign w_hit_cmp = (r_count == r_compare);

    assign w_unused = ^{wdata[31:16], wdata[7:3], addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_irqen      <= 1'b0;
            r_presc      <= 8'd0;
        end else if (w_wr_ctrl) begin
            r_en         <= wdata[0];
            r_autoreload <= wdata[1];
            r_irqen      <= wdata[2];
            r_presc      <= wdata[15:8];
        end else if (w_tick && w_hit_cmp && !r_autoreload) begin
            // One-shot: stop on the matching tick.
            r_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescaler <= 8'd0;
        end else if (w_wr_count) begin
            r_prescaler <= 8'd0;
        end else if (r_en) begin
            r_prescaler <= w_tick ? 8'd0 : r_prescaler + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (w_wr_count) begin
            r_count <= wdata;
        end else if (w_tick) begin
            if (w_hit_cmp) begin
                if (r_autoreload) begin
                    r_count <= 32'd0;
                end
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_compare <= RESET_CMP;
        end else if (w_wr_compare) begin
            r_compare <= wdata;
        end
    end

    // A match raised on this edge outranks a simultaneous clear request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match <= 1'b0;
        end else if (w_tick && w_hit_cmp) begin
            r_match <= 1'b1;
        end else if (w_wr_status && wdata[0]) begin
            r_match <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            case (w_sel)
                c_reg_ctrl:    w_rdata = {16'd0, r_presc, 5'd0, r_irqen, r_autoreload, r_en};
                c_reg_count:   w_rdata = r_count;
                c_reg_compare: w_rdata = r_compare;
                c_reg_status:  w_rdata = {31'd0, r_match};
                default:       w_rdata = 32'd0;
            endcase
        end
    end

    assign rdata = w_rdata;
    assign irq   = r_match & r_irqen;

endmodule
`default_nettype wire

// File: tb/tb_mips_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_timer
// Brief    : Directed self-checking bench for mips_timer with an expectation
//            queue popped at each observation point.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_timer;

    localparam logic [3:0] c_ctrl    = 4'h0;
    localparam logic [3:0] c_count   = 4'h4;
    localparam logic [3:0] c_compare = 4'h8;
    localparam logic [3:0] c_status  = 4'hC;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    mips_timer #(
        .ADDR_W    (4),
        .RESET_CMP (32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        sb_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expectation queued, observed %h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        expect_val(tag, exp);
        cs   = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check_obs(rdata);
        cs = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        expect_val(tag, {31'd0, exp});
        #1;
        check_obs({31'd0, irq});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cs    = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic wr_nocs(input logic [3:0] a, input logic [31:0] d);
        cs    = 1'b0;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        expect_val("nocs_rdata", 32'd0);
        #1;
        check_obs(rdata);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cs    = 1'b0;
        we    = 1'b0;
        addr  = 4'h0;
        wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        rd(c_ctrl,    32'h0,         "rst_ctrl");
        rd(c_count,   32'h0,         "rst_count");
        rd(c_compare, 32'hFFFF_FFFF, "rst_compare");
        rd(c_status,  32'h0,         "rst_status");
        chk_irq(1'b0, "rst_irq");

        // Async reset in the middle of counting
        wr(c_ctrl, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        rd(c_count, 32'd5, "pre_reset_count");
        reset = 1'b1;
        rd(c_count, 32'd0, "async_reset_count");
        rd(c_ctrl,  32'd0, "async_reset_ctrl");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(c_count, 32'd0, "no_resume_count");

        // One-shot with compare
        cs = 1'b1; we = 1'b1; addr = c_compare; wdata = 32'd3;
        expect_val("rdata_during_write", 32'd0);
        #1;
        check_obs(rdata);
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
        wr(c_ctrl, 32'h5);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            rd(c_count, 32'(i), "oneshot_count");
        end
        rd(c_status, 32'd0, "oneshot_status_pre");
        chk_irq(1'b0, "oneshot_irq_pre");
        @(posedge clk);
        #1;
        rd(c_status, 32'd1, "oneshot_match");
        chk_irq(1'b1, "oneshot_irq");
        rd(c_ctrl,  32'h4, "oneshot_en_clr");
        rd(c_count, 32'd3, "oneshot_hold");
        @(posedge clk);
        #1;
        rd(c_count, 32'd3, "oneshot_hold2");

        // irqen masking
        wr(c_ctrl, 32'h0);
        chk_irq(1'b0, "irq_masked");
        rd(c_status, 32'd1, "match_kept_masked");
        wr(c_ctrl, 32'h4);
        chk_irq(1'b1, "irq_unmasked");

        // cs=0 writes are ignored
        wr_nocs(c_ctrl,    32'hDEAD_BEEF);
        wr_nocs(c_count,   32'hDEAD_BEEF);
        wr_nocs(c_compare, 32'hDEAD_BEEF);
        wr_nocs(c_status,  32'hFFFF_FFFF);
        rd(c_ctrl,    32'h4, "nocs_ctrl");
        rd(c_count,   32'd3, "nocs_count");
        rd(c_compare, 32'd3, "nocs_compare");
        rd(c_status,  32'd1, "nocs_status");
        wr(c_status, 32'h0);
        rd(c_status, 32'd1, "w0_no_clear");
        wr(c_status, 32'h1);
        rd(c_status, 32'd0, "w1_clear");
        chk_irq(1'b0, "w1_clear_irq");

        // Autoreload with prescaler 3
        wr(c_count,   32'd0);
        wr(c_compare, 32'd2);
        wr(c_ctrl,    32'h0307);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            rd(c_count, (k == 12) ? 32'd0 : 32'(k / 4), "presc_count");
        end
        rd(c_status, 32'd1, "auto_match");
        chk_irq(1'b1, "auto_irq");
        wr(c_status, 32'h1);
        rd(c_status, 32'd0, "auto_clear");
        chk_irq(1'b0, "auto_clear_irq");

        // Match tick coincides with clear
        repeat (10) @(posedge clk);
        #1;
        wr(c_status, 32'h1);
        rd(c_status, 32'd1, "set_beats_clear");
        rd(c_count,  32'd0, "auto_reload_count");

        // COUNT write on a tick cycle
        repeat (3) @(posedge clk);
        #1;
        wr(c_count, 32'd7);
        rd(c_count, 32'd7, "count_write_wins");
        repeat (3) @(posedge clk);
        #1;
        rd(c_count, 32'd7, "presc_restart_hold");
        @(posedge clk);
        #1;
        rd(c_count, 32'd8, "presc_restart_tick");

        // CTRL write beats one-shot stop
        wr(c_ctrl,    32'h0);
        wr(c_status,  32'h1);
        wr(c_compare, 32'd0);
        wr(c_count,   32'd0);
        wr(c_ctrl,    32'h1);
        wr(c_ctrl,    32'h1);
        rd(c_ctrl,   32'h1, "ctrl_write_wins");
        rd(c_count,  32'd0, "oneshot0_hold");
        rd(c_status, 32'd1, "oneshot0_match");
        @(posedge clk);
        #1;
        rd(c_ctrl, 32'h0, "oneshot0_stop");

        // 32-bit wrap without match
        wr(c_status,  32'h1);
        wr(c_compare, 32'd10);
        wr(c_count,   32'hFFFF_FFFE);
        wr(c_ctrl,    32'h1);
        rd(c_count, 32'hFFFF_FFFE, "wrap_start");
        @(posedge clk);
        #1;
        rd(c_count, 32'hFFFF_FFFF, "wrap_max");
        @(posedge clk);
        #1;
        rd(c_count, 32'h0, "wrap_zero");
        @(posedge clk);
        #1;
        rd(c_count, 32'h1, "wrap_one");
        rd(c_status, 32'd0, "wrap_no_match");

        // Reserved CTRL bits read as zero
        wr(c_ctrl, 32'hFFFF_FF06);
        rd(c_ctrl, 32'h0000_FF06, "ctrl_mask");
        chk_irq(1'b0, "ctrl_mask_irq");

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
